// File: rtl/soundtrack_player.sv
// soundtrack_player: playback sequencer between the soundtrack ROM wrapper and
// the audio mixer/codec serializer.
//
// It walks the sample index 0..depth-1 as the ROM address and waits ROM_LATENCY
// cycles for each word. It then releases one attenuated sample per codec
// sample_tick, loops the track `repeats` times (0 = forever), and pulses done.
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   play, stop      one-cycle start / abort pulses (stop wins over play)
//   sample_tick     one-cycle codec sample-rate strobe
//   vol             arithmetic right-shift attenuation (0 = full scale)
//   depth, repeats  track length and pass count, latched on accepted play
//   rom_dout        signed sample returned by the ROM wrapper
//   rom_addr        sample index driven to the ROM wrapper
//   sample_out      attenuated sample, held between ticks
//   sample_valid    one-cycle pulse when sample_out updates
//   busy            high whenever the sequencer is not idle
//   done            one-cycle pulse after the last sample of the last pass
//   underrun_cnt    saturating count of ticks dropped while one was pending
module soundtrack_player #(
  parameter int unsigned ROM_LATENCY = 3,
  parameter int unsigned VOL_W       = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              stop,
  input  logic              sample_tick,
  input  logic [VOL_W-1:0]  vol,
  input  logic [17:0]       depth,
  input  logic [31:0]       repeats,
  input  logic [15:0]       rom_dout,
  output logic [31:0]       rom_addr,
  output logic [15:0]       sample_out,
  output logic              sample_valid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       underrun_cnt
);

  localparam int unsigned DEPTH_W  = 18;
  localparam int unsigned PASS_W   = 32;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned LAT_W    = 4;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;

  logic [DEPTH_W-1:0]    idx_q, idx_d;
  logic [PASS_W-1:0]     pass_q, pass_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic                  pending_q, pending_d;
  logic [SAMPLE_W-1:0]   buf_q, buf_d;
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic [PASS_W-1:0]     repeats_q, repeats_d;
  logic [SAMPLE_W-1:0]   sample_out_q, sample_out_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      underrun_q, underrun_d;

  // Decode of the current cycle's events
  logic                  at_cap_c;
  logic                  emit_c;
  logic                  last_idx_c;
  logic                  last_pass_c;
  logic                  tick_drop_c;
  logic [SAMPLE_W-1:0]   emit_src_c;
  state_t                adv_state_c;

  // ROM word is valid on the last latency cycle of WAIT
  assign at_cap_c    = (state_q == S_WAIT) && (lat_q == LAT_W'(ROM_LATENCY - 1));

  // A tick seen on the capture cycle is served at once, as is a pending one
  assign emit_c      = ((state_q == S_READY) && sample_tick) ||
                       (at_cap_c && (pending_q || sample_tick));

  // On the capture cycle the fresh ROM word bypasses sample_buf
  assign emit_src_c  = at_cap_c ? rom_dout : buf_q;

  assign last_idx_c  = (idx_q == (depth_q - DEPTH_W'(1)));
  assign last_pass_c = (repeats_q != '0) && ((pass_q + PASS_W'(1)) == repeats_q);

  // A second tick while one is already waiting is lost
  assign tick_drop_c = (state_q == S_WAIT) && sample_tick && pending_q;

  // Where the sequencer goes after emitting a sample
  assign adv_state_c = (last_idx_c && last_pass_c) ? S_DONE : S_WAIT;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop has priority over play, play restarts from any state
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else if (play) begin
      state_d = (depth == '0) ? S_DONE : S_WAIT;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_WAIT: begin
          if (at_cap_c) begin
            state_d = emit_c ? adv_state_c : S_READY;
          end
        end
        S_READY: begin
          if (emit_c) begin
            state_d = adv_state_c;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    idx_d          = idx_q;
    pass_d         = pass_q;
    lat_d          = lat_q;
    pending_d      = pending_q;
    buf_d          = buf_q;
    depth_d        = depth_q;
    repeats_d      = repeats_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    underrun_d     = underrun_q;
    busy_d         = (state_d != S_IDLE);
    done_d         = (state_d == S_DONE);

    if (stop) begin
      // Abort: silence the output but keep the underrun history
      idx_d        = '0;
      lat_d        = '0;
      pending_d    = 1'b0;
      sample_out_d = '0;
    end else if (play) begin
      idx_d      = '0;
      pass_d     = '0;
      lat_d      = '0;
      pending_d  = 1'b0;
      underrun_d = '0;
      depth_d    = depth;
      repeats_d  = repeats;
    end else begin
      if (state_q == S_WAIT) begin
        if (at_cap_c) begin
          buf_d     = rom_dout;
          pending_d = 1'b0;
        end else begin
          lat_d = lat_q + LAT_W'(1);
          if (sample_tick && !pending_q) begin
            pending_d = 1'b1;
          end
        end
        if (tick_drop_c && (underrun_q != '1)) begin
          underrun_d = underrun_q + CNT_W'(1);
        end
      end

      if (emit_c) begin
        sample_out_d   = $signed(emit_src_c) >>> vol;
        sample_valid_d = 1'b1;
        lat_d          = '0;
        if (last_idx_c) begin
          idx_d  = '0;
          pass_d = pass_q + PASS_W'(1);
        end else begin
          idx_d  = idx_q + DEPTH_W'(1);
        end
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q          <= '0;
      pass_q         <= '0;
      lat_q          <= '0;
      pending_q      <= 1'b0;
      buf_q          <= '0;
      depth_q        <= '0;
      repeats_q      <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      underrun_q     <= '0;
    end else begin
      idx_q          <= idx_d;
      pass_q         <= pass_d;
      lat_q          <= lat_d;
      pending_q      <= pending_d;
      buf_q          <= buf_d;
      depth_q        <= depth_d;
      repeats_q      <= repeats_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      underrun_q     <= underrun_d;
    end
  end

  // The ROM address is the sample index, zero-extended
  assign rom_addr     = ADDR_W'(idx_q);
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_soundtrack_player.sv
// Testbench for soundtrack_player: a latency-accurate ROM model feeds the DUT,
// a negedge monitor logs emitted samples and done pulses, and a directed plus
// randomized sequence compares them with values computed from the track rules.
module tb_soundtrack_player;

  localparam int unsigned L  = 3;
  localparam int unsigned VW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           play;
  logic           stop;
  logic           sample_tick;
  logic [VW-1:0]  vol;
  logic [17:0]    depth;
  logic [31:0]    repeats;
  logic [15:0]    rom_dout;
  logic [31:0]    rom_addr;
  logic [15:0]    sample_out;
  logic           sample_valid;
  logic           busy;
  logic           done;
  logic [15:0]    underrun_cnt;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [15:0] got_q[$];
  int          vcyc_q[$];
  int          tick_q[$];
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          play_cyc = 0;

  // ROM model: data for an address is visible L cycles after the address changes
  logic [31:0] addr_pipe [0:L-2];
  logic        rom_const_en = 1'b0;
  logic [15:0] rom_const    = 16'h0000;
  logic [15:0] rom_base     = 16'h1000;

  soundtrack_player #(.ROM_LATENCY(L), .VOL_W(VW)) dut (
    .clk          (clk),
    .reset        (reset),
    .play         (play),
    .stop         (stop),
    .sample_tick  (sample_tick),
    .vol          (vol),
    .depth        (depth),
    .repeats      (repeats),
    .rom_dout     (rom_dout),
    .rom_addr     (rom_addr),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    addr_pipe[0] <= rom_addr;
    for (int k = 1; k < L - 1; k++) addr_pipe[k] <= addr_pipe[k-1];
  end

  assign rom_dout = rom_const_en ? rom_const : 16'(rom_base + addr_pipe[L-2][15:0]);

  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      got_q.push_back(sample_out);
      vcyc_q.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    got_q.delete();
    vcyc_q.delete();
    tick_q.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic do_play();
    play     = 1'b1;
    play_cyc = cyc;
    step();
    play     = 1'b0;
  endtask

  task automatic run_ticks(int n, int gap);
    for (int i = 0; i < n; i++) begin
      step(gap - 1);
      sample_tick = 1'b1;
      tick_q.push_back(cyc);
      step();
      sample_tick = 1'b0;
    end
  endtask

  task automatic wait_samples(int n, int budget, string tag);
    int b;
    b = budget;
    while (got_q.size() < n && b > 0) begin
      step();
      b--;
    end
    chk(tag, 32'(got_q.size()), 32'(n));
  endtask

  // Sign-preserving attenuation as floor division by 2**v
  function automatic logic [15:0] atten(logic [15:0] s, int v);
    int x;
    int p;
    x = int'($signed(s));
    p = 1 << v;
    if (x >= 0) x = x / p;
    else        x = -((-x + p - 1) / p);
    return 16'(x);
  endfunction

  // Check a logged run against the expected track: value, tick latency, done
  task automatic check_track(string tag, int d, int rp, int v, bit chk_lat);
    int k;
    chk($sformatf("%s_count", tag), 32'(got_q.size()), 32'(d * rp));
    for (int p = 0; p < rp; p++) begin
      for (int i = 0; i < d; i++) begin
        k = p * d + i;
        if (k < got_q.size()) begin
          chk($sformatf("%s_val%0d", tag, k), 32'(got_q[k]), 32'(atten(16'(rom_base + 16'(i)), v)));
          if (chk_lat && k < tick_q.size())
            chk($sformatf("%s_lat%0d", tag, k), 32'(vcyc_q[k]), 32'(tick_q[k] + 1));
        end
      end
    end
  endtask

  initial begin
    int d;
    int rp;
    int v;
    int g;

    reset       = 1'b1;
    play        = 1'b0;
    stop        = 1'b0;
    sample_tick = 1'b0;
    vol         = '0;
    depth       = 18'd4;
    repeats     = 32'd1;
    step(3);
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_done",     32'(done), 32'd0);
    chk("rst_valid",    32'(sample_valid), 32'd0);
    chk("rst_sample",   32'(sample_out), 32'd0);
    chk("rst_addr",     rom_addr, 32'd0);
    chk("rst_underrun", 32'(underrun_cnt), 32'd0);
    reset = 1'b0;
    step(2);

    // Basic single pass, ticks every 10 cycles
    clear_log();
    rom_base = 16'h1000;
    do_play();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_addr0", rom_addr, 32'd0);
    run_ticks(4, 10);
    step(3);
    check_track("t1", 4, 1, 0, 1'b1);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    if (vcyc_q.size() == 4) chk("t1_done_cyc", 32'(done_cyc), 32'(vcyc_q[3]));
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_addr_end", rom_addr, 32'd0);

    // Two passes over a 3-sample track
    clear_log();
    depth   = 18'd3;
    repeats = 32'd2;
    do_play();
    run_ticks(6, 7);
    step(3);
    check_track("t2", 3, 2, 0, 1'b1);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);

    // Endless looping, then stop
    clear_log();
    repeats = 32'd0;
    do_play();
    run_ticks(20, 6);
    step(3);
    chk("t3_count", 32'(got_q.size()), 32'd20);
    for (int k = 0; k < 20; k++)
      if (k < got_q.size()) chk($sformatf("t3_val%0d", k), 32'(got_q[k]), 32'(16'(rom_base + 16'(k % 3))));
    chk("t3_no_done", 32'(done_cnt), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t3_stop_busy", 32'(busy), 32'd0);
    chk("t3_stop_sample", 32'(sample_out), 32'd0);

    // Volume shift on extreme samples
    rom_const_en = 1'b1;
    depth        = 18'd1;
    repeats      = 32'd1;
    vol          = 3'd2;
    clear_log();
    rom_const = 16'h8000;
    do_play();
    run_ticks(1, 6);
    step(2);
    chk("t4_neg_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("t4_neg", 32'(got_q[0]), 32'h0000_E000);
    clear_log();
    rom_const = 16'h7FFF;
    do_play();
    run_ticks(1, 6);
    step(2);
    chk("t4_pos_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("t4_pos", 32'(got_q[0]), 32'h0000_1FFF);
    rom_const_en = 1'b0;
    vol          = '0;

    // Tick every cycle: pending path and underruns
    clear_log();
    depth       = 18'd2;
    sample_tick = 1'b1;
    do_play();
    wait_samples(2, 40, "t5_tmo");
    sample_tick = 1'b0;
    step(3);
    check_track("t5", 2, 1, 0, 1'b0);
    if (vcyc_q.size() > 0) chk("t5_first_lat", 32'(vcyc_q[0] - play_cyc), 32'(L + 1));
    chk("t5_underrun", 32'(underrun_cnt), 32'(2 * (L - 1)));
    chk("t5_done_cnt", 32'(done_cnt), 32'd1);

    // Stop after the second sample
    clear_log();
    depth = 18'd4;
    do_play();
    chk("t6_underrun_clr", 32'(underrun_cnt), 32'd0);
    run_ticks(2, 10);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_sample", 32'(sample_out), 32'd0);
    chk("t6_addr", rom_addr, 32'd0);
    step(20);
    chk("t6_count", 32'(got_q.size()), 32'd2);
    chk("t6_no_done", 32'(done_cnt), 32'd0);

    // Play and stop together from idle
    clear_log();
    play = 1'b1;
    stop = 1'b1;
    step();
    play = 1'b0;
    stop = 1'b0;
    chk("t7_busy", 32'(busy), 32'd0);
    step(6);
    chk("t7_count", 32'(got_q.size()), 32'd0);
    chk("t7_no_done", 32'(done_cnt), 32'd0);

    // Empty track
    clear_log();
    depth = 18'd0;
    do_play();
    chk("t8_done", 32'(done), 32'd1);
    chk("t8_busy", 32'(busy), 32'd1);
    step();
    chk("t8_done_fall", 32'(done), 32'd0);
    chk("t8_busy_fall", 32'(busy), 32'd0);
    step(3);
    chk("t8_count", 32'(got_q.size()), 32'd0);
    chk("t8_done_cnt", 32'(done_cnt), 32'd1);

    // Randomized tracks
    for (int r = 0; r < 6; r++) begin
      d  = int'($urandom_range(1, 5));
      rp = int'($urandom_range(1, 3));
      v  = int'($urandom_range(0, 7));
      g  = int'($urandom_range(4, 9));
      depth    = 18'(d);
      repeats  = 32'(rp);
      vol      = VW'(v);
      rom_base = 16'($urandom);
      clear_log();
      do_play();
      run_ticks(d * rp, g);
      step(3);
      check_track($sformatf("rnd%0d", r), d, rp, v, 1'b1);
      chk($sformatf("rnd%0d_done", r), 32'(done_cnt), 32'd1);
      chk($sformatf("rnd%0d_busy", r), 32'(busy), 32'd0);
    end

    // Asynchronous reset in the middle of a fetch
    vol      = '0;
    rom_base = 16'h1000;
    depth    = 18'd4;
    repeats  = 32'd1;
    clear_log();
    do_play();
    run_ticks(1, 6);
    step();
    chk("t9_pre_sample", 32'(sample_out), 32'h0000_1000);
    #2;
    reset = 1'b1;
    #1;
    chk("t9_sample", 32'(sample_out), 32'd0);
    chk("t9_busy", 32'(busy), 32'd0);
    chk("t9_addr", rom_addr, 32'd0);
    chk("t9_valid", 32'(sample_valid), 32'd0);
    chk("t9_done", 32'(done), 32'd0);
    step();
    reset = 1'b0;
    step(8);
    chk("t9_no_done", 32'(done_cnt), 32'd0);
    chk("t9_busy_after", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
